// File: rtl/wb_arbiter.sv
// Writeback arbiter: three per-source result FIFOs drained onto two register-bank
// write ports with round-robin priority and same-destination conflict avoidance.
module wb_arbiter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        alu_valid,
   input  logic        mdu_valid,
   input  logic        lsu_valid,
   output logic        alu_ready,
   output logic        mdu_ready,
   output logic        lsu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [4:0]  mdu_rd,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] alu_data,
   input  logic [31:0] mdu_data,
   input  logic [31:0] lsu_data,
   output logic        wrd_en1,
   output logic        wrd_en2,
   output logic [4:0]  wrd_add1,
   output logic [4:0]  wrd_add2,
   output logic [31:0] wrd_data1,
   output logic [31:0] wrd_data2,
   output logic        busy
);
   localparam int unsigned NSRC = 3;
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CW   = $clog2(DEPTH + 1);

   logic [NSRC-1:0] valid, ready, push, pop, nonempty;
   logic [4:0]      src_rd    [NSRC];
   logic [31:0]     src_data  [NSRC];
   logic [4:0]      head_rd   [NSRC];
   logic [31:0]     head_data [NSRC];

   logic [4:0]      rd_mem_q   [NSRC][DEPTH];
   logic [31:0]     data_mem_q [NSRC][DEPTH];
   logic [AW-1:0]   rptr_q [NSRC], rptr_d [NSRC];
   logic [AW-1:0]   wptr_q [NSRC], wptr_d [NSRC];
   logic [CW-1:0]   cnt_q  [NSRC], cnt_d  [NSRC];
   logic [1:0]      rr_q, rr_d;

   logic            g1_valid, g2_valid, en1, en2;
   logic [1:0]      g1_idx, g2_idx;

   function automatic logic [1:0] next_src(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   assign valid       = {lsu_valid, mdu_valid, alu_valid};
   assign src_rd[0]   = alu_rd;
   assign src_rd[1]   = mdu_rd;
   assign src_rd[2]   = lsu_rd;
   assign src_data[0] = alu_data;
   assign src_data[1] = mdu_data;
   assign src_data[2] = lsu_data;
   assign alu_ready   = ready[0];
   assign mdu_ready   = ready[1];
   assign lsu_ready   = ready[2];

   // Readiness looks only at the registered count, so a full FIFO never
   // accepts in the same cycle it pops.
   always_comb begin
      for (int s = 0; s < NSRC; s++) begin
         nonempty[s]  = (cnt_q[s] != '0);
         ready[s]     = (cnt_q[s] != CW'(DEPTH)) & ~flush & reset;
         push[s]      = valid[s] & ready[s] & (src_rd[s] != 5'd0);
         head_rd[s]   = rd_mem_q[s][rptr_q[s]];
         head_data[s] = data_mem_q[s][rptr_q[s]];
      end
   end

   // NOTE: every variable driven here gets a value before any branch, so no
   // path through the block can leave it holding state and infer a latch.
   always_comb begin
      logic [1:0] idx;
      g1_valid = 1'b0;
      g1_idx   = 2'd0;
      g2_valid = 1'b0;
      g2_idx   = 2'd0;
      idx      = rr_q;
      for (int k = 0; k < NSRC; k++) begin
         if (nonempty[idx]) begin
            if (!g1_valid) begin
               g1_valid = 1'b1;
               g1_idx   = idx;
            end else if (!g2_valid && (head_rd[idx] != head_rd[g1_idx])) begin
               g2_valid = 1'b1;
               g2_idx   = idx;
            end
         end
         idx = next_src(idx);
      end
   end

   assign en1       = g1_valid & ~flush & reset;
   assign en2       = g2_valid & ~flush & reset;
   assign wrd_en1   = en1;
   assign wrd_en2   = en2;
   assign wrd_add1  = en1 ? head_rd[g1_idx]   : 5'd0;
   assign wrd_add2  = en2 ? head_rd[g2_idx]   : 5'd0;
   assign wrd_data1 = en1 ? head_data[g1_idx] : 32'd0;
   assign wrd_data2 = en2 ? head_data[g2_idx] : 32'd0;
   assign busy      = reset & (|nonempty);

   always_comb begin
      pop = '0;
      if (en1) pop[g1_idx] = 1'b1;
      if (en2) pop[g2_idx] = 1'b1;
      rr_d = rr_q;
      if (en2)      rr_d = next_src(g2_idx);
      else if (en1) rr_d = next_src(g1_idx);
   end

   always_comb begin
      for (int s = 0; s < NSRC; s++) begin
         rptr_d[s] = rptr_q[s];
         wptr_d[s] = wptr_q[s];
         cnt_d[s]  = cnt_q[s];
         if (flush) begin
            rptr_d[s] = '0;
            wptr_d[s] = '0;
            cnt_d[s]  = '0;
         end else begin
            if (push[s]) wptr_d[s] = wptr_q[s] + 1'b1;
            if (pop[s])  rptr_d[s] = rptr_q[s] + 1'b1;
            case ({push[s], pop[s]})
               2'b10:   cnt_d[s] = cnt_q[s] + 1'b1;
               2'b01:   cnt_d[s] = cnt_q[s] - 1'b1;
               default: cnt_d[s] = cnt_q[s];
            endcase
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_q <= 2'd0;
         for (int s = 0; s < NSRC; s++) begin
            rptr_q[s] <= '0;
            wptr_q[s] <= '0;
            cnt_q[s]  <= '0;
         end
      end else begin
         rr_q <= rr_d;
         for (int s = 0; s < NSRC; s++) begin
            rptr_q[s] <= rptr_d[s];
            wptr_q[s] <= wptr_d[s];
            cnt_q[s]  <= cnt_d[s];
         end
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only read while the
   // count says it was written, so its power-up contents never reach a port.
   always_ff @(posedge clk) begin
      for (int s = 0; s < NSRC; s++) begin
         if (push[s]) begin
            rd_mem_q[s][wptr_q[s]]   <= src_rd[s];
            data_mem_q[s][wptr_q[s]] <= src_data[s];
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        alu_valid, mdu_valid, lsu_valid;
   logic        alu_ready, mdu_ready, lsu_ready;
   logic [4:0]  alu_rd, mdu_rd, lsu_rd;
   logic [31:0] alu_data, mdu_data, lsu_data;
   logic        wrd_en1, wrd_en2;
   logic [4:0]  wrd_add1, wrd_add2;
   logic [31:0] wrd_data1, wrd_data2;
   logic        busy;

   int vectors    = 0;
   int miscompares = 0;

   typedef logic [36:0] entry_t;   // {rd, data}
   entry_t model_q [3][$];
   int     model_rr = 0;
   logic [2:0] accepted;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .alu_valid(alu_valid), .mdu_valid(mdu_valid), .lsu_valid(lsu_valid),
      .alu_ready(alu_ready), .mdu_ready(mdu_ready), .lsu_ready(lsu_ready),
      .alu_rd(alu_rd), .mdu_rd(mdu_rd), .lsu_rd(lsu_rd),
      .alu_data(alu_data), .mdu_data(mdu_data), .lsu_data(lsu_data),
      .wrd_en1(wrd_en1), .wrd_en2(wrd_en2),
      .wrd_add1(wrd_add1), .wrd_add2(wrd_add2),
      .wrd_data1(wrd_data1), .wrd_data2(wrd_data2),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step(input logic [2:0] v, input logic [4:0] r0, r1, r2,
                       input logic [31:0] d0, d1, d2, input logic fl, input logic rs);
      logic [2:0]  exp_rdy;
      int          g1, g2, i;
      logic        e1, e2, any;
      logic [4:0]  rds [3];
      logic [31:0] dts [3];
      @(negedge clk);
      {lsu_valid, mdu_valid, alu_valid} = v;
      alu_rd = r0; mdu_rd = r1; lsu_rd = r2;
      alu_data = d0; mdu_data = d1; lsu_data = d2;
      flush = fl; reset = rs;
      rds = '{r0, r1, r2};
      dts = '{d0, d1, d2};
      #1;
      g1 = -1; g2 = -1; any = 1'b0;
      for (int s = 0; s < 3; s++) begin
         exp_rdy[s] = rs && !fl && (model_q[s].size() != DEPTH);
         if (model_q[s].size() > 0) any = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         i = (model_rr + k) % 3;
         if (model_q[i].size() > 0) begin
            if (g1 < 0) g1 = i;
            else if (g2 < 0 && model_q[i][0][36:32] != model_q[g1][0][36:32]) g2 = i;
         end
      end
      e1 = (g1 >= 0) && !fl && rs;
      e2 = (g2 >= 0) && !fl && rs;
      check("ready", {lsu_ready, mdu_ready, alu_ready}, exp_rdy);
      check("en1", wrd_en1, e1);
      check("add1", wrd_add1, e1 ? model_q[g1][0][36:32] : 5'd0);
      check("data1", wrd_data1, e1 ? model_q[g1][0][31:0] : 32'd0);
      check("en2", wrd_en2, e2);
      check("add2", wrd_add2, e2 ? model_q[g2][0][36:32] : 5'd0);
      check("data2", wrd_data2, e2 ? model_q[g2][0][31:0] : 32'd0);
      check("busy", busy, rs && any);
      accepted = v & exp_rdy;
      if (!rs || fl) begin
         for (int s = 0; s < 3; s++) model_q[s].delete();
         if (!rs) model_rr = 0;
      end else begin
         if (e1) void'(model_q[g1].pop_front());
         if (e2) void'(model_q[g2].pop_front());
         if (e2)      model_rr = (g2 + 1) % 3;
         else if (e1) model_rr = (g1 + 1) % 3;
         for (int s = 0; s < 3; s++)
            if (accepted[s] && rds[s] != 5'd0) model_q[s].push_back({rds[s], dts[s]});
      end
   endtask

   task automatic idle();
      step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
   endtask

   initial begin
      int mdu_n;
      logic [4:0] seen [$];
      {alu_valid, mdu_valid, lsu_valid, flush} = '0;
      reset = 1'b0;
      {alu_rd, mdu_rd, lsu_rd} = '0;
      {alu_data, mdu_data, lsu_data} = '0;

      // Reset held with all sources offering results.
      repeat (3) step(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
      idle();
      check("rst_ready", {lsu_ready, mdu_ready, alu_ready}, 3'b111);
      check("rst_busy", busy, 1'b0);

      // Single ALU write: visible the cycle after acceptance, gone the cycle after.
      step(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0, 1'b1);
      idle();
      check("single_en1", wrd_en1, 1'b1);
      check("single_add1", wrd_add1, 5'd5);
      check("single_data1", wrd_data1, 32'hDEADBEEF);
      check("single_en2", wrd_en2, 1'b0);
      idle();
      check("single_busy", busy, 1'b0);

      // Route one LSU result through so the round-robin pointer returns to ALU.
      step(3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h99, 1'b0, 1'b1);
      idle();

      // Three-way round robin.
      step(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 1'b0, 1'b1);
      idle();
      check("rr_add1", wrd_add1, 5'd1);
      check("rr_add2", wrd_add2, 5'd2);
      idle();
      check("rr_add1b", wrd_add1, 5'd3);
      check("rr_en2b", wrd_en2, 1'b0);

      // Same-rd conflict between ALU and LSU heads.
      step(3'b101, 5'd7, 5'd0, 5'd7, 32'h11, 32'd0, 32'h22, 1'b0, 1'b1);
      idle();
      check("conf_add1", wrd_add1, 5'd7);
      check("conf_data1", wrd_data1, 32'h11);
      check("conf_en2", wrd_en2, 1'b0);
      idle();
      check("conf_add1b", wrd_add1, 5'd7);
      check("conf_data1b", wrd_data1, 32'h22);

      // MDU backpressure and pointer wrap while ALU/LSU compete for ports.
      mdu_n = 0;
      for (int c = 0; c < 40; c++) begin
         step({c < 20, mdu_n < 6, c < 20}, 5'd20, 5'(8 + mdu_n), 5'd21,
              32'(c), 32'h100 + 32'(mdu_n), 32'(c), 1'b0, 1'b1);
         if (wrd_en1 && wrd_add1 >= 8 && wrd_add1 <= 13) seen.push_back(wrd_add1);
         if (wrd_en2 && wrd_add2 >= 8 && wrd_add2 <= 13) seen.push_back(wrd_add2);
         if (accepted[1]) mdu_n++;
      end
      check("bp_count", seen.size(), 6);
      for (int k = 0; k < seen.size(); k++) check("bp_order", seen[k], 8 + k);

      // Flush with all FIFOs populated.
      repeat (3) step(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1);
      step(3'b111, 5'd4, 5'd5, 5'd6, 32'h4, 32'h5, 32'h6, 1'b1, 1'b1);
      check("flush_en1", wrd_en1, 1'b0);
      check("flush_en2", wrd_en2, 1'b0);
      idle();
      check("flush_busy", busy, 1'b0);

      // Writes to x0 are accepted and dropped.
      step(3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h55, 1'b0, 1'b1);
      check("x0_ready", lsu_ready, 1'b1);
      idle();
      check("x0_en1", wrd_en1, 1'b0);
      check("x0_busy", busy, 1'b0);

      // Randomized traffic with small rd range to provoke conflicts and x0.
      for (int c = 0; c < 2000; c++) begin
         step({$urandom_range(0, 99) < 55, $urandom_range(0, 99) < 55,
               $urandom_range(0, 99) < 55},
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom,
              $urandom_range(0, 49) == 0, $urandom_range(0, 149) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
